// File: rtl/wb_gpio_ctrl.sv
// wb_gpio_ctrl
// Wishbone classic slave that owns the 38 user I/O pads. A single-cycle
// transfer is decoded into a small register bank that drives the pad
// output data and output-enable lines and reads back synchronised pad
// inputs. Each request is acknowledged for exactly one cycle.
//
// Optional feature macro: GPIO_IRQ_EN
//   defined   - rising-edge detectors on pins 0-31, IRQ_EN / IRQ_STAT
//               registers, and user_irq[0] interrupt output.
//   undefined - edge logic removed; 0x18/0x1C read 0, ignore writes,
//               still acknowledge; user_irq is constant 0.
//
// Ports:
//   wb_clk_i, wb_rst_ni         clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i        Wishbone request qualifiers
//   wbs_adr_i[31:0]             byte address (offset = adr[5:2])
//   wbs_dat_i[31:0], wbs_sel_i  write data and byte enables
//   wbs_ack_o, wbs_dat_o[31:0]  acknowledge and read data (0 when idle)
//   io_in[37:0]                 asynchronous pad inputs
//   io_out[37:0], io_oeb[37:0]  pad output data, active-low output enable
//   user_irq[2:0]               [0] GPIO interrupt, [2:1] tied 0
`timescale 1ns/1ps
module wb_gpio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFC0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic [2:0]  user_irq
);

  localparam logic [3:0] OFF_OUT_LO   = 4'h0;
  localparam logic [3:0] OFF_OUT_HI   = 4'h1;
  localparam logic [3:0] OFF_OEB_LO   = 4'h2;
  localparam logic [3:0] OFF_OEB_HI   = 4'h3;
  localparam logic [3:0] OFF_IN_LO    = 4'h4;
  localparam logic [3:0] OFF_IN_HI    = 4'h5;
  localparam logic [3:0] OFF_IRQ_EN   = 4'h6;
  localparam logic [3:0] OFF_IRQ_STAT = 4'h7;

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic [37:0] out_q, out_d;
  logic [37:0] oeb_q, oeb_d;
  logic [37:0] sync1_q, sync1_d;
  logic [37:0] sync2_q, sync2_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        hit, req, wr, rd;
  logic [3:0]  offset;
  logic [31:0] rd_mux;
  logic [31:0] hi_tmp;
  logic [31:0] irq_en_rd, irq_stat_rd;

  // Request decode. The !ack term makes a held strobe re-accept only
  // every second cycle.
  always_comb begin
    hit    = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    req    = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    wr     = req & wbs_we_i;
    rd     = req & ~wbs_we_i;
    offset = wbs_adr_i[5:2];
  end

  always_comb begin
    out_d   = out_q;
    oeb_d   = oeb_q;
    hi_tmp  = '0;
    sync1_d = io_in;
    sync2_d = sync1_q;
    if (wr) begin
      case (offset)
        OFF_OUT_LO: out_d[31:0] = byte_merge(out_q[31:0], wbs_dat_i, wbs_sel_i);
        OFF_OUT_HI: begin
          hi_tmp       = byte_merge({26'b0, out_q[37:32]}, wbs_dat_i, wbs_sel_i);
          out_d[37:32] = hi_tmp[5:0];
        end
        OFF_OEB_LO: oeb_d[31:0] = byte_merge(oeb_q[31:0], wbs_dat_i, wbs_sel_i);
        OFF_OEB_HI: begin
          hi_tmp       = byte_merge({26'b0, oeb_q[37:32]}, wbs_dat_i, wbs_sel_i);
          oeb_d[37:32] = hi_tmp[5:0];
        end
        default: ;
      endcase
    end
  end

  // Read data is captured at the request edge and presented only during
  // the ack cycle; the bus sees 0 at all other times.
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_OUT_LO:   rd_mux = out_q[31:0];
      OFF_OUT_HI:   rd_mux = {26'b0, out_q[37:32]};
      OFF_OEB_LO:   rd_mux = oeb_q[31:0];
      OFF_OEB_HI:   rd_mux = {26'b0, oeb_q[37:32]};
      OFF_IN_LO:    rd_mux = sync2_q[31:0];
      OFF_IN_HI:    rd_mux = {26'b0, sync2_q[37:32]};
      OFF_IRQ_EN:   rd_mux = irq_en_rd;
      OFF_IRQ_STAT: rd_mux = irq_stat_rd;
      default:      rd_mux = '0;
    endcase
    ack_d = req;
    dat_d = rd ? rd_mux : 32'h0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q   <= '0;
      oeb_q   <= '1;
      sync1_q <= '0;
      sync2_q <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [31:0] prev_q, prev_d;
  logic [31:0] irq_en_q, irq_en_d;
  logic [31:0] irq_stat_q, irq_stat_d;
  logic [31:0] rise, clr;

  // A fresh edge wins over a same-cycle W1C so no event is lost.
  always_comb begin
    prev_d   = sync2_q[31:0];
    rise     = sync2_q[31:0] & ~prev_q;
    irq_en_d = irq_en_q;
    clr      = '0;
    if (wr && offset == OFF_IRQ_EN)
      irq_en_d = byte_merge(irq_en_q, wbs_dat_i, wbs_sel_i);
    if (wr && offset == OFF_IRQ_STAT)
      clr = byte_merge(32'h0, wbs_dat_i, wbs_sel_i);
    irq_stat_d = (irq_stat_q & ~clr) | rise;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      prev_q     <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
    end else begin
      prev_q     <= prev_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
    end
  end

  assign irq_en_rd   = irq_en_q;
  assign irq_stat_rd = irq_stat_q;
  // Pure AND-OR of flop outputs, so the interrupt line cannot glitch
  // on bus activity.
  assign user_irq    = {2'b00, |(irq_stat_q & irq_en_q)};
`else
  assign irq_en_rd   = '0;
  assign irq_stat_rd = '0;
  assign user_irq    = 3'b000;
`endif

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
`timescale 1ns/1ps
module tb_wb_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] io_in, io_out, io_oeb;
  logic [2:0]  user_irq;

  always #5 clk = ~clk;

  wb_gpio_ctrl dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_sel_i(sel),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .user_irq (user_irq)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: the register bank as the programmer sees it.
  logic [37:0] m_out, m_oeb, m_in;
  logic [31:0] m_en, m_stat;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic model_irq();
`ifdef GPIO_IRQ_EN
    return |(m_stat & m_en);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0: return m_out[31:0];
      1: return {26'b0, m_out[37:32]};
      2: return m_oeb[31:0];
      3: return {26'b0, m_oeb[37:32]};
      4: return m_in[31:0];
      5: return {26'b0, m_in[37:32]};
`ifdef GPIO_IRQ_EN
      6: return m_en;
      7: return m_stat;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input int off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    logic [31:0] cur;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) mask[b*8 +: 8] = 8'hFF;
    cur = model_read(off);
    cur = (cur & ~mask) | (d & mask);
    case (off)
      0: m_out[31:0]  = cur;
      1: m_out[37:32] = cur[5:0];
      2: m_oeb[31:0]  = cur;
      3: m_oeb[37:32] = cur[5:0];
`ifdef GPIO_IRQ_EN
      6: m_en = cur;
      7: m_stat = m_stat & ~(d & mask);
`endif
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_out = '0; m_oeb = '1; m_in = '0; m_en = '0; m_stat = '0;
  endtask

  // Monitor: pops one expectation per ack and checks idle data is 0.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack=1 expected ack=0 (nothing outstanding)");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_rd) check("rdata", {32'h0, rdat}, {32'h0, e.data});
        end
      end else begin
        check("dat_idle", {32'h0, rdat}, 64'h0);
      end
    end
  end

  // One transfer. Entered and left at posedge+1. edge_set models a
  // rising-edge latch landing on the same edge as the request.
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] edge_set);
    logic inwin;
    inwin = (a & 32'hFFFF_FFC0) == BASE;
    if (inwin) exp_q.push_back('{is_rd: ~w, data: (w ? 32'h0 : model_read(int'(a[5:2])))});
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (inwin && w) model_write(int'(a[5:2]), d, s);
`ifdef GPIO_IRQ_EN
    m_stat = m_stat | edge_set;
`endif
    check("io_out", {26'h0, io_out}, {26'h0, m_out});
    check("io_oeb", {26'h0, io_oeb}, {26'h0, m_oeb});
    check("user_irq", {61'h0, user_irq}, {61'h0, 2'b00, model_irq()});
    @(posedge clk); #1;
    check("ack_seen", 64'(exp_q.size()), 64'h0);
  endtask

  // Change pads and let them settle through sync and edge detect.
  task automatic set_in(input logic [37:0] nv);
    logic [37:0] rise;
    rise  = nv & ~m_in;
    io_in = nv;
    repeat (4) @(posedge clk);
    #1;
    m_in = nv;
`ifdef GPIO_IRQ_EN
    m_stat = m_stat | rise[31:0];
`endif
  endtask

  initial begin
    logic [63:0] r64;
    cyc = 0; stb = 0; we = 0; adr = '0; wdat = '0; sel = '0; io_in = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_io_oeb", {26'h0, io_oeb}, {26'h0, 38'h3F_FFFF_FFFF});
    check("rst_io_out", {26'h0, io_out}, 64'h0);
    check("rst_ack", {63'h0, ack}, 64'h0);
    check("rst_irq", {61'h0, user_irq}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte-enable write and readback.
    wb_xfer(BASE + 32'h00, 1'b1, 32'hA5A5_A5A5, 4'b0101, 32'h0);
    check("be_out", {32'h0, io_out[31:0]}, 64'h00A5_00A5);
    wb_xfer(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0);

    // Out-of-window write held for 4 cycles: no ack, no change.
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h40; wdat = 32'hFFFF_FFFF; sel = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    cyc = 0; stb = 0; we = 0;
    check("oow_out", {26'h0, io_out}, {26'h0, m_out});
    check("oow_oeb", {26'h0, io_oeb}, {26'h0, m_oeb});

    // Sustained strobe: accepted at k and k+2 only.
    exp_q.push_back('{is_rd: 1'b1, data: model_read(2)});
    exp_q.push_back('{is_rd: 1'b1, data: model_read(2)});
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h08;
    repeat (4) @(posedge clk);
    #1;
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    check("sustained_acks", 64'(exp_q.size()), 64'h0);

    // Input sync: change before edge j, read accepted at edge j+2.
    io_in = m_in | 38'h08_0000_0000;
    repeat (2) @(posedge clk);
    #1;
    m_in = io_in;
    wb_xfer(BASE + 32'h14, 1'b0, 32'h0, 4'hF, 32'h0);
    check("in_hi_bit3", 64'(m_in[35]), 64'h1);

    // Interrupt on pin 5 with exact latency.
    wb_xfer(BASE + 32'h18, 1'b1, 32'h20, 4'hF, 32'h0);
    io_in = m_in | 38'h20;
    repeat (2) @(posedge clk);
    #1;
    check("irq_before", {61'h0, user_irq}, 64'h0);
    @(posedge clk); #1;
    m_in = io_in;
`ifdef GPIO_IRQ_EN
    m_stat = m_stat | 32'h20;
`endif
    check("irq_after", {61'h0, user_irq}, {61'h0, 2'b00, model_irq()});
    wb_xfer(BASE + 32'h1C, 1'b0, 32'h0, 4'hF, 32'h0);
    wb_xfer(BASE + 32'h1C, 1'b1, 32'h20, 4'hF, 32'h0);

    // Collision: W1C and a new edge land on the same edge.
    set_in(m_in & ~38'h20);
    set_in(m_in | 38'h20);
    set_in(m_in & ~38'h20);
    io_in = m_in | 38'h20;
    repeat (2) @(posedge clk);
    #1;
    m_in = io_in;
    wb_xfer(BASE + 32'h1C, 1'b1, 32'h20, 4'hF, 32'h20);
    wb_xfer(BASE + 32'h1C, 1'b0, 32'h0, 4'hF, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 120; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a  = BASE + ($urandom_range(0, 15) << 2);
      if (op < 4) begin
        wb_xfer(a, 1'b1, $urandom, 4'($urandom_range(0, 15)), 32'h0);
      end else if (op < 8) begin
        wb_xfer(a, 1'b0, 32'h0, 4'hF, 32'h0);
      end else begin
        r64 = {$urandom, $urandom};
        set_in(r64[37:0]);
        check("rand_irq", {61'h0, user_irq}, {61'h0, 2'b00, model_irq()});
      end
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
